// File: rtl/proj_pkg.sv
// proj_pkg: shared Q8.8 types, constants, FSM states and ALU opcodes
// for the projection matrix sequencer.
package proj_pkg;

    typedef logic signed [15:0] q8_8_t;
    typedef logic signed [15:0] q2_12_t;
    typedef logic signed [23:0] wide_t;

    localparam q8_8_t       Q_ONE        = 16'sh0100;
    localparam logic [11:0] PI_DIV_2_Q48 = 12'h192;
    localparam logic [11:0] PI_Q48       = 12'h324;
    localparam q8_8_t       SAT_MAX      = 16'sh7FFF;
    localparam q8_8_t       SAT_MIN      = 16'sh8000;
    localparam int          NUM_STEPS    = 8;

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_K_DIV      = 4'd1,
        ST_SIN_H      = 4'd2,
        ST_COS_H      = 4'd3,
        ST_INVTAN_DIV = 4'd4,
        ST_M0_DIV     = 4'd5,
        ST_M10_MUL    = 4'd6,
        ST_NF_MUL     = 4'd7,
        ST_M11_MUL    = 4'd8,
        ST_FIN        = 4'd9,
        ST_FIN_ERR    = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        OP_DIV,
        OP_MUL,
        OP_MUL2,
        OP_SIN
    } alu_op_t;

    typedef struct packed {
        logic [11:0] eye_fov;
        q8_8_t       aspect_ratio;
        q8_8_t       z_near;
        q8_8_t       z_far;
    } cam_t;

    function automatic state_t next_step(input state_t st);
        state_t nx;
        nx = ST_IDLE;
        case (st)
            ST_K_DIV:      nx = ST_SIN_H;
            ST_SIN_H:      nx = ST_COS_H;
            ST_COS_H:      nx = ST_INVTAN_DIV;
            ST_INVTAN_DIV: nx = ST_M0_DIV;
            ST_M0_DIV:     nx = ST_M10_MUL;
            ST_M10_MUL:    nx = ST_NF_MUL;
            ST_NF_MUL:     nx = ST_M11_MUL;
            ST_M11_MUL:    nx = ST_FIN;
            default:       nx = ST_IDLE;
        endcase
        return nx;
    endfunction

    // Q2.12 -> Q8.8 with round-half-up
    function automatic q8_8_t q212_to_q88(input q2_12_t v);
        logic signed [16:0] r;
        r = 17'(v) + 17'sd8;
        return q8_8_t'(r >>> 4);
    endfunction

    function automatic q8_8_t sat16(input logic signed [39:0] v);
        if (v > 40'sd32767)
            return SAT_MAX;
        if (v < -40'sd32768)
            return SAT_MIN;
        return v[15:0];
    endfunction

    function automatic logic is_ovf(input logic signed [39:0] v);
        return (v > 40'sd32767) || (v < -40'sd32768);
    endfunction

endpackage

// File: rtl/proj_matrix_sequencer_alu.sv
// proj_shared_alu: one Q8.8 multiplier, one Q8.8 divider and one sine
// approximation behind an opcode mux; purely combinational.
import proj_pkg::*;

module proj_shared_alu (
    input  alu_op_t op,
    input  wide_t   a,
    input  q8_8_t   b,
    output q8_8_t   result,
    output wide_t   result_wide,
    output logic    overflow,
    output logic    div_by_zero
);

    logic signed [39:0] prod;
    logic signed [39:0] prod_sh;
    logic signed [39:0] mul_v;
    logic signed [39:0] div_num;
    logic signed [39:0] div_den;
    logic signed [39:0] div_q;
    logic               b_zero;

    // Angle in Q4.8 radians, folded into [0, pi/2], odd Taylor to x^5
    function automatic q2_12_t fxp_sin(input wide_t ang);
        logic        neg;
        logic [31:0] x;
        logic [31:0] x12;
        logic [31:0] x2;
        logic [31:0] x3;
        logic [31:0] x5;
        logic [31:0] p;
        neg = ang[23];
        x   = neg ? 32'(-ang) : 32'(ang);
        for (int i = 0; i < 2; i++) begin
            if (x >= 32'(PI_Q48)) begin
                x   = x - 32'(PI_Q48);
                neg = ~neg;
            end
        end
        if (x > 32'(PI_DIV_2_Q48))
            x = 32'(PI_Q48) - x;
        x12 = x << 4;
        x2  = (x12 * x12) >> 12;
        x3  = (x2 * x12) >> 12;
        x5  = (x3 * x2) >> 12;
        p   = x12 - ((x3 * 32'd683) >> 12)
                  + ((x5 * 32'd34) >> 12);
        return q2_12_t'(neg ? -p : p);
    endfunction

    assign prod    = 40'(a) * 40'(b);
    assign prod_sh = prod >>> 8;
    assign mul_v   = (op == OP_MUL2) ? (prod_sh <<< 1) : prod_sh;
    assign b_zero  = (b == '0);
    assign div_num = 40'($signed({a, 8'h00}));
    assign div_den = 40'(b);
    assign div_q   = b_zero ? '0 : (div_num / div_den);

    always_comb begin
        result      = '0;
        result_wide = '0;
        overflow    = 1'b0;
        div_by_zero = 1'b0;
        unique case (op)
            OP_MUL, OP_MUL2: begin
                result      = sat16(mul_v);
                overflow    = is_ovf(mul_v);
                result_wide = prod_sh[23:0];
            end
            OP_DIV: begin
                result      = sat16(div_q);
                overflow    = is_ovf(div_q);
                div_by_zero = b_zero;
            end
            OP_SIN: begin
                result = fxp_sin(a);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/proj_matrix_sequencer.sv
// proj_matrix_sequencer: builds the Q8.8 perspective projection matrix
// over several cycles on one shared div/mul/sin datapath.
import proj_pkg::*;

module proj_matrix_sequencer #(
    parameter int STEP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [11:0] eye_fov,
    input  logic [15:0] aspect_ratio,
    input  logic [15:0] z_near,
    input  logic [15:0] z_far,
    output logic        busy,
    output logic        done,
    output logic        matrix_valid,
    output logic        err,
    output logic        ovf,
    output logic [15:0] projection_matrix [16]
);

    localparam logic [3:0] STEP_LAST = 4'(STEP_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  step_cnt;
    logic        step_last;
    logic        arith;
    logic        is_div;
    logic        abort;
    cam_t        cam;
    logic [11:0] h;
    q8_8_t       k;
    q8_8_t       s;
    q8_8_t       c;
    q8_8_t       it;
    q8_8_t       m0;
    q8_8_t       m10;
    wide_t       t;

    alu_op_t     alu_op;
    wide_t       alu_a;
    q8_8_t       alu_b;
    q8_8_t       alu_res;
    wide_t       alu_wide;
    logic        alu_ovf;
    logic        alu_dz;

    assign h         = cam.eye_fov >> 1;
    assign arith     = (state != ST_IDLE) &&
                       (state <= state_t'(NUM_STEPS));
    assign is_div    = (state == ST_K_DIV) ||
                       (state == ST_INVTAN_DIV) ||
                       (state == ST_M0_DIV);
    assign step_last = (step_cnt == STEP_LAST);
    assign abort     = is_div && alu_dz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == ST_IDLE) begin
            if (start)
                state_nxt = ST_K_DIV;
        end else if (arith) begin
            if (step_last)
                state_nxt = abort ? ST_FIN_ERR : next_step(state);
        end else begin
            state_nxt = ST_IDLE;
        end
    end

    always_comb begin
        busy = arith;
        done = (state == ST_FIN) || (state == ST_FIN_ERR);
    end

    always_comb begin
        alu_op = OP_MUL;
        alu_a  = '0;
        alu_b  = '0;
        unique case (state)
            ST_K_DIV: begin
                alu_op = OP_DIV;
                alu_a  = wide_t'(Q_ONE);
                alu_b  = cam.z_far - cam.z_near;
            end
            ST_SIN_H: begin
                alu_op = OP_SIN;
                alu_a  = {12'd0, h};
            end
            ST_COS_H: begin
                alu_op = OP_SIN;
                alu_a  = {12'd0, PI_DIV_2_Q48} - {12'd0, h};
            end
            ST_INVTAN_DIV: begin
                alu_op = OP_DIV;
                alu_a  = wide_t'(c);
                alu_b  = s;
            end
            ST_M0_DIV: begin
                alu_op = OP_DIV;
                alu_a  = wide_t'(it);
                alu_b  = cam.aspect_ratio;
            end
            ST_M10_MUL: begin
                alu_a = -(wide_t'(cam.z_near) + wide_t'(cam.z_far));
                alu_b = k;
            end
            ST_NF_MUL: begin
                alu_a = wide_t'(cam.z_near);
                alu_b = cam.z_far;
            end
            ST_M11_MUL: begin
                alu_op = OP_MUL2;
                alu_a  = t;
                alu_b  = k;
            end
            default: ;
        endcase
    end

    proj_shared_alu u_alu (
        .op          (alu_op),
        .a           (alu_a),
        .b           (alu_b),
        .result      (alu_res),
        .result_wide (alu_wide),
        .overflow    (alu_ovf),
        .div_by_zero (alu_dz)
    );

    // Matrix and valid only change together, entering FIN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cam          <= '0;
            step_cnt     <= '0;
            k            <= '0;
            s            <= '0;
            c            <= '0;
            it           <= '0;
            m0           <= '0;
            m10          <= '0;
            t            <= '0;
            matrix_valid <= 1'b0;
            err          <= 1'b0;
            ovf          <= 1'b0;
            for (int i = 0; i < 16; i++)
                projection_matrix[i] <= '0;
        end else if (state == ST_IDLE) begin
            step_cnt <= '0;
            if (start) begin
                cam          <= {eye_fov, aspect_ratio, z_near, z_far};
                err          <= 1'b0;
                ovf          <= 1'b0;
                matrix_valid <= 1'b0;
            end
        end else if (arith) begin
            if (!step_last) begin
                step_cnt <= step_cnt + 4'd1;
            end else begin
                step_cnt <= '0;
                ovf      <= ovf | alu_ovf;
                if (abort)
                    err <= 1'b1;
                case (state)
                    ST_K_DIV:      k   <= alu_res;
                    ST_SIN_H:      s   <= q212_to_q88(alu_res);
                    ST_COS_H:      c   <= q212_to_q88(alu_res);
                    ST_INVTAN_DIV: it  <= alu_res;
                    ST_M0_DIV:     m0  <= alu_res;
                    ST_M10_MUL:    m10 <= alu_res;
                    ST_NF_MUL:     t   <= alu_wide;
                    ST_M11_MUL: begin
                        for (int i = 0; i < 16; i++)
                            projection_matrix[i] <= '0;
                        projection_matrix[0]  <= m0;
                        projection_matrix[5]  <= it;
                        projection_matrix[10] <= m10;
                        projection_matrix[11] <= alu_res;
                        projection_matrix[14] <= Q_ONE;
                        matrix_valid          <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_proj_matrix_sequencer.sv
// tb_proj_matrix_sequencer: directed vectors with hand-computed
// expected matrices for the projection matrix sequencer.
module tb_proj_matrix_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        start3;
    logic [11:0] eye_fov;
    logic [15:0] aspect_ratio;
    logic [15:0] z_near;
    logic [15:0] z_far;

    logic        busy, done, mv, err, ovf;
    logic [15:0] pm [16];
    logic        busy3, done3, mv3, err3, ovf3;
    logic [15:0] pm3 [16];

    int cyc    = 0;
    int n_chk  = 0;
    int n_pass = 0;
    int lat;
    int nb;
    int n;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    proj_matrix_sequencer dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .eye_fov           (eye_fov),
        .aspect_ratio      (aspect_ratio),
        .z_near            (z_near),
        .z_far             (z_far),
        .busy              (busy),
        .done              (done),
        .matrix_valid      (mv),
        .err               (err),
        .ovf               (ovf),
        .projection_matrix (pm)
    );

    proj_matrix_sequencer #(.STEP_CYCLES(3)) dut3 (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start3),
        .eye_fov           (eye_fov),
        .aspect_ratio      (aspect_ratio),
        .z_near            (z_near),
        .z_far             (z_far),
        .busy              (busy3),
        .done              (done3),
        .matrix_valid      (mv3),
        .err               (err3),
        .ovf               (ovf3),
        .projection_matrix (pm3)
    );

    task automatic check(input string tag, input int got,
                         input int exp, input int tol);
        int d;
        n_chk++;
        d = (got > exp) ? got - exp : exp - got;
        if (d <= tol)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h want 0x%0h (tol %0d)",
                     tag, got, exp, tol);
    endtask

    // Accept at edge T; lat is the cycle index (T+lat) in which done shows
    task automatic run(input string tag, input bit use3,
                       input logic [11:0] f, input logic [15:0] a,
                       input logic [15:0] zn, input logic [15:0] zf,
                       input bit poke, output int lat_o,
                       output int nb_o);
        int t0;
        eye_fov      = f;
        aspect_ratio = a;
        z_near       = zn;
        z_far        = zf;
        if (use3) start3 = 1'b1;
        else      start  = 1'b1;
        @(posedge clk); #1;
        t0     = cyc;
        start  = 1'b0;
        start3 = 1'b0;
        nb_o   = 0;
        while (!(use3 ? done3 : done) && (cyc - t0) < 60) begin
            if (use3 ? busy3 : busy)
                nb_o++;
            if (poke && (cyc - t0) == 2) begin
                start        = 1'b1;
                aspect_ratio = 16'h0100;
                z_near       = 16'h0200;
                z_far        = 16'h0200;
            end
            if (poke && (cyc - t0) == 5)
                start = 1'b0;
            @(posedge clk); #1;
        end
        lat_o = cyc - t0 + 1;
        check({tag, " done"}, int'(use3 ? done3 : done), 1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        start3       = 1'b0;
        eye_fov      = '0;
        aspect_ratio = '0;
        z_near       = '0;
        z_far        = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst flags", {busy, done, mv, err, ovf}, 0, 0);
        check("rst flags3", {busy3, done3, mv3, err3, ovf3}, 0, 0);
        check("rst m14", pm[14], 0, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // nominal
        run("nom", 0, 12'h192, 16'h0100, 16'h0100, 16'h0300, 0, lat, nb);
        check("nom lat", lat, 9, 0);
        check("nom busy", nb, 8, 0);
        check("nom err", err, 0, 0);
        check("nom ovf", ovf, 0, 0);
        check("nom valid", mv, 1, 0);
        check("nom m0", pm[0], 16'h0100, 1);
        check("nom m5", pm[5], 16'h0100, 1);
        check("nom m10", pm[10], 16'hFE00, 0);
        check("nom m11", pm[11], 16'h0300, 0);
        check("nom m14", pm[14], 16'h0100, 0);
        check("nom m1", pm[1], 0, 0);
        check("nom m15", pm[15], 0, 0);
        @(posedge clk); #1;
        check("nom done pulse", done, 0, 0);

        // aspect 2.0
        run("asp2", 0, 12'h192, 16'h0200, 16'h0100, 16'h0300, 0, lat, nb);
        check("asp2 m0", pm[0], 16'h0080, 1);
        check("asp2 m5", pm[5], 16'h0100, 1);
        check("asp2 valid", mv, 1, 0);
        @(posedge clk); #1;

        // z_near == z_far
        run("zeq", 0, 12'h192, 16'h0100, 16'h0200, 16'h0200, 0, lat, nb);
        check("zeq lat", lat, 2, 0);
        check("zeq err", err, 1, 0);
        check("zeq valid", mv, 0, 0);
        check("zeq keep m0", pm[0], 16'h0080, 0);
        check("zeq keep m10", pm[10], 16'hFE00, 0);
        check("zeq keep m14", pm[14], 16'h0100, 0);
        @(posedge clk); #1;

        // zero fov -> sin(h) == 0
        run("fov0", 0, 12'h000, 16'h0100, 16'h0100, 16'h0300, 0, lat, nb);
        check("fov0 lat", lat, 5, 0);
        check("fov0 err", err, 1, 0);
        @(posedge clk); #1;

        // zero aspect
        run("asp0", 0, 12'h192, 16'h0000, 16'h0100, 16'h0300, 0, lat, nb);
        check("asp0 lat", lat, 6, 0);
        check("asp0 err", err, 1, 0);
        @(posedge clk); #1;

        // near*far overflows Q8.8
        run("ovf", 0, 12'h192, 16'h0100, 16'h4000, 16'h7000, 0, lat, nb);
        check("ovf lat", lat, 9, 0);
        check("ovf flag", ovf, 1, 0);
        check("ovf err", err, 0, 0);
        check("ovf valid", mv, 1, 0);
        check("ovf m11", pm[11], 16'h7FFF, 0);
        check("ovf m10", pm[10], 16'hFC90, 0);
        @(posedge clk); #1;

        // start and input changes while busy
        run("poke", 0, 12'h192, 16'h0200, 16'h0100, 16'h0300, 1, lat, nb);
        check("poke lat", lat, 9, 0);
        check("poke m0", pm[0], 16'h0080, 1);
        check("poke m10", pm[10], 16'hFE00, 0);
        check("poke err", err, 0, 0);
        check("poke ovf", ovf, 0, 0);
        @(posedge clk); #1;
        n = 0;
        repeat (15) begin
            if (done)
                n++;
            @(posedge clk); #1;
        end
        check("poke extra done", n, 0, 0);

        // reset in the middle of a run
        eye_fov      = 12'h192;
        aspect_ratio = 16'h0100;
        z_near       = 16'h0100;
        z_far        = 16'h0300;
        start        = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid busy", busy, 1, 0);
        rst_n = 1'b0;
        #1;
        check("mid rst flags", {busy, done, mv, err, ovf}, 0, 0);
        check("mid rst m14", pm[14], 0, 0);
        check("mid rst m0", pm[0], 0, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run("fresh", 0, 12'h192, 16'h0100, 16'h0100, 16'h0300, 0, lat, nb);
        check("fresh lat", lat, 9, 0);
        check("fresh valid", mv, 1, 0);
        check("fresh m11", pm[11], 16'h0300, 0);
        @(posedge clk); #1;

        // STEP_CYCLES = 3
        run("s3", 1, 12'h192, 16'h0100, 16'h0100, 16'h0300, 0, lat, nb);
        check("s3 lat", lat, 25, 0);
        check("s3 busy", nb, 24, 0);
        check("s3 valid", mv3, 1, 0);
        check("s3 m0", pm3[0], 16'h0100, 1);
        check("s3 m10", pm3[10], 16'hFE00, 0);
        check("s3 m11", pm3[11], 16'h0300, 0);
        check("s3 err", err3, 0, 0);
        @(posedge clk); #1;
        check("s3 done pulse", done3, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
